// File: rtl/mult_sc_pkg.sv
// Shared types and helpers for the self-composed shift-add multiplier.
package mult_sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cw_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_seq.sv
// One shift-add multiplier copy: FSM, datapath and cycle counter.
module mult_seq
    import mult_sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cw_f(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               const_time,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [2*WIDTH-1:0] out,
    output logic               finish,
    output logic [CW-1:0]      cycles
);

    state_t               state;
    state_t               state_nx;
    logic [2*WIDTH-1:0]   a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [CW-1:0]        cnt;
    logic                 ct;
    logic                 load;
    logic                 run;
    logic                 last;

    assign acc_nx = acc + (b[0] ? a : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        run      = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                run  = 1'b1;
                // early exit only when no multiplier bits remain
                last = (cnt == CW'(WIDTH - 1)) ||
                       (!ct && (b[WIDTH-1:1] == '0));
                if (last) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            ct     <= 1'b0;
            out    <= '0;
            finish <= 1'b0;
            cycles <= '0;
        end else if (load) begin
            a      <= {{WIDTH{1'b0}}, in1};
            b      <= in2;
            acc    <= '0;
            cnt    <= '0;
            ct     <= const_time;
            finish <= 1'b0;
        end else if (run) begin
            acc <= acc_nx;
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt + CW'(1);
            if (last) begin
                out    <= acc_nx;
                cycles <= cnt + CW'(1);
                finish <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sc_n.sv
// N-copy self-composition of mult_seq with a sticky completion-mismatch monitor.
module mult_sc_n
    import mult_sc_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCOPY = 2,
    localparam int CW    = cw_f(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     const_time,
    input  logic [NCOPY*WIDTH-1:0]   in1,
    input  logic [NCOPY*WIDTH-1:0]   in2,
    output logic [NCOPY*2*WIDTH-1:0] out,
    output logic [NCOPY-1:0]         finish,
    output logic [NCOPY*CW-1:0]      cycles,
    output logic                     done_all,
    output logic                     leak
);

    for (genvar i = 0; i < NCOPY; i++) begin : g_copy
        mult_seq #(
            .WIDTH (WIDTH),
            .CW    (CW)
        ) u_seq (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .const_time (const_time),
            .in1        (in1[i*WIDTH +: WIDTH]),
            .in2        (in2[i*WIDTH +: WIDTH]),
            .out        (out[i*2*WIDTH +: 2*WIDTH]),
            .finish     (finish[i]),
            .cycles     (cycles[i*CW +: CW])
        );
    end

    assign done_all = &finish;

    // copies that disagree on completion reveal operand-dependent timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          leak <= 1'b0;
        else if (|finish && !(&finish))   leak <= 1'b1;
    end

endmodule

// File: tb/tb_mult_sc_n.sv
// Self-checking bench: vector table, random ops vs. arithmetic model, corner sequences.
module tb_mult_sc_n;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ct1;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [31:0] out;
    logic [1:0]  fin;
    logic [7:0]  cyc;
    logic        done_all;
    logic        leak;

    logic        start2;
    logic        ct2;
    logic [63:0] in1w;
    logic [63:0] in2w;
    logic [127:0] outw;
    logic [3:0]  finw;
    logic [19:0] cycw;
    logic        donew;
    logic        leakw;

    int nvec;
    int nerr;

    mult_sc_n #(.WIDTH(8), .NCOPY(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .const_time(ct1), .in1(in1), .in2(in2),
        .out(out), .finish(fin), .cycles(cyc),
        .done_all(done_all), .leak(leak)
    );

    mult_sc_n #(.WIDTH(16), .NCOPY(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .const_time(ct2), .in1(in1w), .in2(in2w),
        .out(outw), .finish(finw), .cycles(cycw),
        .done_all(donew), .leak(leakw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            ct;
        logic [1:0][7:0] a;
        logic [1:0][7:0] b;
        logic [1:0][15:0] p;
        logic [1:0][3:0] n;
    } vec_t;

    vec_t vt[6];

    function automatic vec_t mk(
        input logic ct, input logic [7:0] a0, a1,
        input logic [7:0] b0, b1,
        input logic [15:0] p0, p1,
        input logic [3:0] n0, n1);
        vec_t v;
        v.ct = ct;
        v.a  = {a1, a0};
        v.b  = {b1, b0};
        v.p  = {p1, p0};
        v.n  = {n1, n0};
        return v;
    endfunction

    // run length from the operand rules alone
    function automatic int nrun(input int w, input bit c,
                                input logic [15:0] m);
        if (c) return w;
        for (int i = w - 1; i >= 0; i--)
            if (m[i]) return i + 1;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run8(input bit ct, input logic [7:0] a0, a1,
                        input logic [7:0] b0, b1,
                        input logic [15:0] p0, p1,
                        input int n0, n1, input bit lk);
        int mx;
        mx = (n0 > n1) ? n0 : n1;
        @(negedge clk);
        ct1   = ct;
        in1   = {a1, a0};
        in2   = {b1, b0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= mx; k++) begin
            if (k > 0) @(negedge clk);
            chk("fin0", fin[0], k >= n0);
            chk("fin1", fin[1], k >= n1);
        end
        chk("out0", out[15:0], p0);
        chk("out1", out[31:16], p1);
        chk("cyc0", cyc[3:0], n0);
        chk("cyc1", cyc[7:4], n1);
        chk("done_all", done_all, 1);
        chk("leak", leak, lk);
    endtask

    task automatic run16(input bit ct, input logic [3:0][15:0] a,
                         input logic [3:0][15:0] b, input bit lk);
        int n[4];
        int mx;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            n[i] = nrun(16, ct, b[i]);
            if (n[i] > mx) mx = n[i];
        end
        @(negedge clk);
        ct2    = ct;
        in1w   = a;
        in2w   = b;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("w_fin_start", finw, 0);
        repeat (mx) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("w_out", outw[i*32 +: 32], 32'(a[i]) * 32'(b[i]));
            chk("w_cyc", cycw[i*5 +: 5], n[i]);
        end
        chk("w_done", donew, 1);
        chk("w_leak", leakw, lk);
    endtask

    initial begin
        bit lk_m;
        logic [7:0] ra0, ra1, rb0, rb1;
        logic [3:0][15:0] wa, wb;
        int rn0, rn1;
        bit rct;

        nvec   = 0;
        nerr   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ct1    = 1'b0;
        in1    = '0;
        in2    = '0;
        start2 = 1'b0;
        ct2    = 1'b0;
        in1w   = '0;
        in2w   = '0;

        vt[0] = mk(1, 13, 200, 11, 255, 143, 51000, 8, 8);
        vt[1] = mk(0, 5, 5, 1, 8'h80, 5, 640, 1, 8);
        vt[2] = mk(0, 7, 9, 3, 3, 21, 27, 2, 2);
        vt[3] = mk(0, 77, 3, 0, 0, 0, 0, 1, 1);
        vt[4] = mk(0, 255, 255, 255, 255, 65025, 65025, 8, 8);
        vt[5] = mk(0, 1, 2, 64, 2, 64, 4, 7, 2);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_fin", fin, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_leak", leak, 0);
        chk("rst_done", done_all, 0);
        chk("rst_w_fin", finw, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            run8(vt[v].ct, vt[v].a[0], vt[v].a[1],
                 vt[v].b[0], vt[v].b[1],
                 vt[v].p[0], vt[v].p[1],
                 int'(vt[v].n[0]), int'(vt[v].n[1]),
                 vt[v].n[0] != vt[v].n[1]);
        end

        // leak stays set across a later balanced operation
        do_reset();
        run8(0, 5, 5, 1, 8'h80, 5, 640, 1, 8, 1);
        run8(1, 13, 200, 11, 255, 143, 51000, 8, 8, 1);

        // random back-to-back ops against the arithmetic model
        do_reset();
        lk_m = 0;
        for (int r = 0; r < 24; r++) begin
            rct = 1'($urandom_range(0, 1));
            ra0 = 8'($urandom);
            ra1 = 8'($urandom);
            rb0 = 8'($urandom) >> $urandom_range(0, 7);
            rb1 = 8'($urandom) >> $urandom_range(0, 7);
            rn0 = nrun(8, rct, {8'd0, rb0});
            rn1 = nrun(8, rct, {8'd0, rb1});
            lk_m = lk_m | (rn0 != rn1);
            run8(rct, ra0, ra1, rb0, rb1,
                 16'(ra0) * 16'(rb0), 16'(ra1) * 16'(rb1),
                 rn0, rn1, lk_m);
        end

        // start during RUN is ignored; start in DONE restarts
        do_reset();
        @(negedge clk);
        ct1 = 1'b1;
        in1 = 16'hffff;
        in2 = 16'hffff;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        in1 = 16'h0101;
        in2 = 16'h0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ign_fin7", fin, 0);
        @(negedge clk);
        chk("ign_fin8", fin, 2'b11);
        chk("ign_out", out, {16'd65025, 16'd65025});
        chk("ign_cyc", cyc, {4'd8, 4'd8});
        ct1 = 1'b0;
        in1 = {8'd3, 8'd3};
        in2 = {8'd3, 8'd3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_fin_drop", fin, 0);
        chk("rs_out_held", out, {16'd65025, 16'd65025});
        repeat (2) @(negedge clk);
        chk("rs_fin", fin, 2'b11);
        chk("rs_out", out, {16'd9, 16'd9});
        chk("rs_cyc", cyc, {4'd2, 4'd2});

        // async reset in the middle of a run
        do_reset();
        run8(0, 5, 5, 1, 8'h80, 5, 640, 1, 8, 1);
        @(negedge clk);
        ct1 = 1'b1;
        in1 = {8'd200, 8'd13};
        in2 = {8'd255, 8'd11};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_out", out, 0);
        chk("ar_fin", fin, 0);
        chk("ar_cyc", cyc, 0);
        chk("ar_leak", leak, 0);
        chk("ar_done", done_all, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("ar_stay_fin", fin, 0);
        chk("ar_stay_out", out, 0);

        // 4-copy, 16-bit instance
        do_reset();
        wa = {16'($urandom), 16'($urandom), 16'd200, 16'd13};
        wb = {16'($urandom), 16'($urandom), 16'd255, 16'd11};
        run16(1, wa, wb, 0);
        lk_m = 0;
        for (int r = 0; r < 8; r++) begin
            rct = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                wa[i] = 16'($urandom);
                wb[i] = 16'($urandom) >> $urandom_range(0, 15);
            end
            for (int i = 1; i < 4; i++)
                if (nrun(16, rct, wb[i]) != nrun(16, rct, wb[0]))
                    lk_m = 1;
            run16(rct, wa, wb, lk_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
